// File: rtl/acc_result_fifo.sv
// -----------------------------------------------------------------------------
// acc_result_fifo
//
// Downstream stage of the accumulator block. Each rising edge of Done captures
// ACC_Out into a small show-ahead FIFO. Results are handed to the consumer
// over a valid/ready handshake. A result that arrives while the buffer is full
// (and no pop frees a slot in the same cycle) is dropped, and the sticky
// Overflow flag is raised.
//
// Ports:
//   Clk        in   1          system clock, rising-edge state updates
//   Reset      in   1          asynchronous, active-low reset
//   Done       in   1          accumulator completion flag (level or pulse)
//   ACC_Out    in   DATA_W     accumulator result, valid while Done high
//   Out_Ready  in   1          consumer accepts Out_Data this cycle
//   Clr_Ovf    in   1          synchronous clear of Overflow
//   Out_Valid  out  1          FIFO head holds a result
//   Out_Data   out  DATA_W     FIFO head result (0 when empty)
//   Full       out  1          DEPTH entries stored
//   Empty      out  1          no entries stored
//   Level      out  PTR_W+1    number of stored entries, 0..DEPTH
//   Overflow   out  1          sticky: a result was dropped while full
// -----------------------------------------------------------------------------
module acc_result_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       Done,
    input  logic [DATA_W-1:0]          ACC_Out,
    input  logic                       Out_Ready,
    input  logic                       Clr_Ovf,
    output logic                       Out_Valid,
    output logic [DATA_W-1:0]          Out_Data,
    output logic                       Full,
    output logic                       Empty,
    output logic [$clog2(DEPTH):0]     Level,
    output logic                       Overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W:0]  PTR_ZERO = {(PTR_W+1){1'b0}};
    localparam logic [PTR_W:0]  PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]  FULL_LVL = (PTR_W+1)'(DEPTH);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    // Pointers carry one extra bit so full and empty are distinguishable
    // while the low PTR_W bits address the storage.
    logic [PTR_W:0]      wr_ptr_q;
    logic [PTR_W:0]      wr_ptr_d;
    logic [PTR_W:0]      rd_ptr_q;
    logic [PTR_W:0]      rd_ptr_d;
    logic                done_q;
    logic                ovf_q;
    logic                ovf_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [PTR_W:0]      level_s;
    logic                empty_s;
    logic                full_s;
    logic                push_s;
    logic                pop_s;
    logic                accept_s;
    logic                drop_s;

    // Occupancy, handshake strobes and next-state for pointers and Overflow.
    always_comb begin
        level_s  = wr_ptr_q - rd_ptr_q;
        empty_s  = (level_s == PTR_ZERO);
        full_s   = (level_s == FULL_LVL);
        // done_q resets high, so Done held across reset release must first
        // be seen low before it can produce a capture.
        push_s   = Done & ~done_q;
        // Pop depends only on registered state plus Out_Ready; Out_Ready
        // while empty is ignored.
        pop_s    = ~empty_s & Out_Ready;
        // When full, a same-cycle pop frees the slot the push then reuses.
        accept_s = push_s & (~full_s | pop_s);
        drop_s   = push_s & full_s & ~pop_s;

        if (accept_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (Clr_Ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state: pointers, Done edge detector and sticky Overflow.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            done_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            done_q   <= Done;
            ovf_q    <= ovf_d;
        end
    end

    // Result storage; contents are intentionally not reset, the pointers
    // alone define which entries are live.
    always_ff @(posedge Clk) begin
        if (accept_s) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= ACC_Out;
        end else begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= mem_q[wr_ptr_q[PTR_W-1:0]];
        end
    end

    // Outputs derive from registered state only; the head is masked to zero
    // when nothing is stored so stale memory never leaks out.
    always_comb begin
        Out_Valid = ~empty_s;
        Empty     = empty_s;
        Full      = full_s;
        Level     = level_s;
        Overflow  = ovf_q;
        if (empty_s) begin
            Out_Data = DATA_ZERO;
        end else begin
            Out_Data = mem_q[rd_ptr_q[PTR_W-1:0]];
        end
    end

endmodule

// File: tb/tb_acc_result_fifo.sv
// -----------------------------------------------------------------------------
// tb_acc_result_fifo
//
// Directed, table-driven bench for acc_result_fifo (DATA_W=8, DEPTH=4).
// Each table row holds the inputs for one clock cycle and the outputs
// expected just after that cycle's rising edge. A hand-written sequence
// covers reset asserted mid-cycle with Done held high across release.
// -----------------------------------------------------------------------------
module tb_acc_result_fifo;

    logic       clk;
    logic       rst_n;
    logic       done;
    logic [7:0] acc;
    logic       rdy;
    logic       clr;
    logic       out_valid;
    logic [7:0] out_data;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic       ovf;

    int n_vec  = 0;
    int n_fail = 0;

    acc_result_fifo #(.DATA_W(8), .DEPTH(4)) dut (
        .Clk       (clk),
        .Reset     (rst_n),
        .Done      (done),
        .ACC_Out   (acc),
        .Out_Ready (rdy),
        .Clr_Ovf   (clr),
        .Out_Valid (out_valid),
        .Out_Data  (out_data),
        .Full      (full),
        .Empty     (empty),
        .Level     (level),
        .Overflow  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       done;
        logic [7:0] acc;
        logic       rdy;
        logic       clr;
        logic       e_valid;
        logic [7:0] e_data;
        logic [2:0] e_level;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic d, input logic [7:0] a,
                                input logic y, input logic c, input logic [2:0] lv,
                                input logic [7:0] dat, input logic o);
        vec_t v;
        v.rst_n   = r;
        v.done    = d;
        v.acc     = a;
        v.rdy     = y;
        v.clr     = c;
        v.e_level = lv;
        v.e_valid = (lv != 3'd0);
        v.e_data  = dat;
        v.e_ovf   = o;
        return v;
    endfunction

    // Full and Empty expectations follow from the expected level.
    task automatic check(input string name, input logic e_valid, input logic [7:0] e_data,
                         input logic [2:0] e_level, input logic e_ovf);
        logic e_full;
        logic e_empty;
        e_full  = (e_level == 3'd4);
        e_empty = (e_level == 3'd0);
        n_vec++;
        if (out_valid !== e_valid || out_data !== e_data || level !== e_level ||
            full !== e_full || empty !== e_empty || ovf !== e_ovf) begin
            n_fail++;
            $display("FAIL %s: got valid=%b data=%h level=%0d full=%b empty=%b ovf=%b, expected valid=%b data=%h level=%0d full=%b empty=%b ovf=%b",
                     name, out_valid, out_data, level, full, empty, ovf,
                     e_valid, e_data, e_level, e_full, e_empty, e_ovf);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        done  = 1'b0;
        acc   = 8'h00;
        rdy   = 1'b0;
        clr   = 1'b0;

        //              rst   done  acc    rdy   clr   level  data   ovf
        // reset and release
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        // three pulses, then drain back-to-back
        vecs.push_back(mk(1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 3'd1, 8'h12, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 8'h12, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h34, 1'b0, 1'b0, 3'd2, 8'h12, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h12, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h56, 1'b0, 1'b0, 3'd3, 8'h12, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 8'h34, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h56, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        // Done held five cycles -> one entry; low then high -> second entry
        vecs.push_back(mk(1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 3'd1, 8'h7F, 1'b0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 3'd1, 8'h7F, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 8'h7F, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 3'd2, 8'h7F, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h7F, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        // fill to four, drop 0x05, drain, clear Overflow
        vecs.push_back(mk(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 3'd1, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 3'd2, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 3'd3, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 3'd4, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 3'd4, 8'h01, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 8'h02, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 8'h03, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h04, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0));
        // fill, then push+pop while full; then drop+clear in one cycle
        vecs.push_back(mk(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 3'd1, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 3'd2, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 3'd3, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd3, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 3'd4, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 8'h01, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 3'd4, 8'h02, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 8'h02, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'hBB, 1'b0, 1'b1, 3'd4, 8'h02, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 8'h02, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 8'h03, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 8'h04, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 8'hAA, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        // three entries ahead of the mid-cycle reset sequence
        vecs.push_back(mk(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 3'd1, 8'h11, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd1, 8'h11, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 3'd2, 8'h11, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h11, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 3'd3, 8'h11, 1'b0));

        // Apply each row for one cycle and check just after the edge.
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            done  = vecs[i].done;
            acc   = vecs[i].acc;
            rdy   = vecs[i].rdy;
            clr   = vecs[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data,
                  vecs[i].e_level, vecs[i].e_ovf);
        end

        // Reset asserted between edges clears the FIFO at once.
        #2;
        done  = 1'b1;
        acc   = 8'h44;
        rst_n = 1'b0;
        #1;
        check("midcycle_reset", 1'b0, 8'h00, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Done still high after release: no capture.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("held_done_after_reset%0d", k), 1'b0, 8'h00, 3'd0, 1'b0);
        end
        done = 1'b0;
        @(posedge clk);
        #1;
        check("done_low_after_reset", 1'b0, 8'h00, 3'd0, 1'b0);
        done = 1'b1;
        acc  = 8'h55;
        @(posedge clk);
        #1;
        check("first_capture_after_reset", 1'b1, 8'h55, 3'd1, 1'b0);
        done = 1'b0;
        rdy  = 1'b1;
        @(posedge clk);
        #1;
        check("pop_after_reset", 1'b0, 8'h00, 3'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_result_fifo.md
Name: acc_result_fifo

Overview:
Downstream stage of the accumulator block. It captures each finished accumulator result, using the rising edge of Done to sample ACC_Out, into a small show-ahead FIFO. It then hands results to the consumer over a valid/ready handshake. It decouples accumulation completion from consumer availability and flags any result lost to a full buffer.

Parameters:
DATA_W, 8, width of ACC_Out and of each stored result
DEPTH, 4, number of FIFO entries; must be a power of 2, >= 2
PTR_W, $clog2(DEPTH), derived, not overridable; address width

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset  in  1  asynchronous, active-low reset
Done  in  1  completion flag from accumulator; level or pulse tolerated
ACC_Out  in  DATA_W  accumulator result, valid while Done high
Out_Ready  in  1  consumer can accept Out_Data this cycle
Clr_Ovf  in  1  synchronous clear of Overflow
Out_Valid  out  1  FIFO head holds a result
Out_Data  out  DATA_W  FIFO head result
Full  out  1  DEPTH entries stored
Empty  out  1  zero entries stored
Level  out  PTR_W+1  number of stored entries, 0..DEPTH
Overflow  out  1  sticky: a result was dropped because FIFO was full

Behaviour:
- Reset (Reset=0, async):
  - wr_ptr=0, rd_ptr=0, Overflow=0, done_d=1.
  - Outputs: Out_Valid=0, Empty=1, Full=0, Level=0, Out_Data=0.
  - Memory contents are not reset.
- Capture strobe: push = Done & ~done_d. done_d <= Done every cycle.
  - Exactly one push per Done rising edge, whether Done is a 1-cycle pulse or held for N cycles.
  - done_d resets to 1, so Done held high across reset release produces no push until Done has been seen low.
- Push: on the push cycle, ACC_Out is written to mem[wr_ptr] at the clock edge, and wr_ptr increments.
  - Latency: Out_Valid/Level reflect the entry on the cycle after the Done rising edge.
  - No combinational bypass from ACC_Out to Out_Data.
- Pointers are PTR_W+1 bits with natural wrap.
  - Level = wr_ptr - rd_ptr.
  - Empty = (Level==0); Full = (Level==DEPTH).
- Show-ahead output:
  - Out_Valid = ~Empty.
  - Out_Data = mem[rd_ptr[PTR_W-1:0]] when Out_Valid, else 0.
  - Both are driven from registers only; no combinational path from Out_Ready.
- Pop = Out_Valid & Out_Ready; rd_ptr increments at the clock edge. Out_Ready while Empty is ignored.
- Handshake rules:
  - Once Out_Valid=1, Out_Data stays stable until popped. Pushes never alter the head entry.
  - The consumer may hold Out_Ready high continuously, giving one result per cycle.
- Simultaneous push and pop:
  - Not full: both occur, Level unchanged.
  - Full: the pop frees a slot and the push is accepted. Level stays DEPTH, Overflow unaffected.
  - Empty: only the push occurs, since pop requires Out_Valid.
- Full without pop and push: ACC_Out is discarded; pointers and memory are unchanged; Overflow <= 1.
- Overflow:
  - Sticky until Clr_Ovf=1 or reset.
  - If a drop and Clr_Ovf occur in the same cycle, set wins (Overflow=1).
  - Overflow never blocks further pushes once space exists.
- Reset mid-operation: all stored results are lost immediately (Empty=1 asynchronously). The handshake restarts cleanly after release.
- Order: strictly first-in, first-out; no reordering, no duplication.

Test Plan:
- Reset release, Done low, Out_Ready=0 -> Out_Valid=0, Empty=1, Level=0, Out_Data=0x00, Overflow=0.
- Done pulses with ACC_Out=0x12, 0x34, 0x56 (Out_Ready=0), then Out_Ready=1 -> Level 1,2,3 on the cycles after each edge; Out_Data pops 0x12, 0x34, 0x56 on consecutive cycles; then Empty=1.
- Done held high for 5 cycles with ACC_Out=0x7F -> exactly one entry, Level=1; Done low then high again -> Level=2.
- Fill 4 entries (0x01..0x04, Out_Ready=0), then Done edge with 0x05 -> Full=1, Level=4, Overflow=1, 0x05 absent. Drain yields 0x01..0x04. Clr_Ovf=1 -> Overflow=0.
- Full, and on the same cycle Done edge (0xAA) with Out_Ready=1 -> 0x01 popped, 0xAA accepted, Level=4, Overflow=0. Drain order is 0x02, 0x03, 0x04, 0xAA.
- Level=3, assert Reset=0 mid-cycle -> Out_Valid drops immediately. After release with Done held high -> no capture until Done goes low then high.
